// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: steps generator freq_select between lo_sel and hi_sel with per-index dwell; SWEEP_SYNC_ZERO_EN aligns index changes to wave_in==0
module freq_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [2:0]         lo_sel,
  input  logic [2:0]         hi_sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         wave_in,
  output logic [2:0]         freq_select,
  output logic               gen_reset,
  output logic               busy,
  output logic               step_pulse,
  output logic               done,
  output logic               err
);
  typedef enum logic [2:0] {IDLE, ARM, DWELL, SYNC, FIN} state_t;
  state_t state, nstate;
  logic [1:0] mode_r;
  logic [2:0] lo_r, hi_r, nidx;
  logic [DWELL_W-1:0] dwell_r, cnt;
  logic dir_r, ndir, accept, reject, expire, adv, fin, at_hi, at_lo;
  assign accept = state == IDLE && start && !stop && lo_sel <= hi_sel;
  assign reject = state == IDLE && start && !stop && lo_sel > hi_sel;
  assign expire = state == DWELL && cnt == dwell_r - DWELL_W'(1);
`ifdef SWEEP_SYNC_ZERO_EN
  assign adv = state == SYNC && wave_in == 8'd0;
`else
  logic unused_wave;
  assign unused_wave = ^wave_in;
  assign adv = expire;
`endif
  assign at_hi = freq_select == hi_r;
  assign at_lo = freq_select == lo_r;
  // dir_r is 1 while climbing; only continuous mode ever turns back up at lo
  assign fin = lo_r == hi_r || (mode_r == 2'b00 && at_hi) || (mode_r == 2'b01 && at_lo) ||
               (mode_r == 2'b10 && !dir_r && at_lo);
  assign ndir = dir_r ? !at_hi : at_lo;
  assign nidx = ndir ? freq_select + 3'd1 : freq_select - 3'd1;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  nstate = accept ? ARM : IDLE;
      ARM:   nstate = stop ? IDLE : DWELL;
`ifdef SWEEP_SYNC_ZERO_EN
      DWELL: nstate = stop ? IDLE : expire ? SYNC : DWELL;
`else
      DWELL: nstate = stop ? IDLE : !expire ? DWELL : fin ? FIN : DWELL;
`endif
      SYNC:  nstate = stop ? IDLE : !adv ? SYNC : fin ? FIN : DWELL;
      FIN:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  always_comb begin
    busy = state == ARM || state == DWELL || state == SYNC;
    gen_reset = state == ARM;
    done = state == FIN;
  end
  always_ff @(posedge clk)
    if (reset) begin
      freq_select <= '0;
      step_pulse <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      mode_r <= '0;
      lo_r <= '0;
      hi_r <= '0;
      dwell_r <= '0;
      dir_r <= 1'b0;
    end else begin
      err <= reject;
      step_pulse <= adv && !stop && !fin;
      cnt <= (state == DWELL && !expire && !stop) ? cnt + DWELL_W'(1) : '0;
      if (accept) begin
        mode_r <= mode;
        lo_r <= lo_sel;
        hi_r <= hi_sel;
        dwell_r <= dwell == '0 ? DWELL_W'(1) : dwell;
        dir_r <= mode != 2'b01;
        freq_select <= mode == 2'b01 ? hi_sel : lo_sel;
      end else if (adv && !stop && !fin) begin
        freq_select <= nidx;
        dir_r <= ndir;
      end
    end
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: randomized scoreboard bench; expected event lists come from index sequences built per sweep mode
module tb_freq_sweep_ctrl;
`ifdef SWEEP_SYNC_ZERO_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif
  typedef struct {int kind; int val; int cyc;} ev_t;
  logic clk = 0, reset = 1, start = 0, stop = 0;
  logic [1:0] mode = 0;
  logic [2:0] lo_sel = 0, hi_sel = 0;
  logic [15:0] dwell = 0;
  logic [7:0] wave_in = 0;
  logic [2:0] freq_select;
  logic gen_reset, busy, step_pulse, done, err;
  ev_t sbq[$];
  int checks = 0, errors = 0, cyc = 0, cur_exp = 0, busy_lo = 1 << 30, busy_hi = -1;
  freq_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .lo_sel(lo_sel), .hi_sel(hi_sel), .dwell(dwell), .wave_in(wave_in),
    .freq_select(freq_select), .gen_reset(gen_reset), .busy(busy),
    .step_pulse(step_pulse), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  // monitor: kinds 0 gen_reset, 1 step, 2 done, 3 err
  always @(posedge clk) begin : mon
    int k;
    ev_t e;
    #1;
    if (!reset) begin
      if (gen_reset || step_pulse || done || err) begin
        k = gen_reset ? 0 : step_pulse ? 1 : done ? 2 : 3;
        if (sbq.size() == 0) chk("unexpected_event", k, -1);
        else begin
          e = sbq.pop_front();
          chk("ev_kind", k, e.kind);
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_freq", int'(freq_select), e.val);
          if (e.kind < 2) cur_exp = e.val;
        end
      end
      chk("freq_hold", int'(freq_select), cur_exp);
      chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end
  task automatic sweep(input int m, input int lo, input int hi, input int dw, input int stop_rel, input bit poke);
    int seq[$];
    int k, per, n, dc, s, endc, c;
    bit finite;
    if (m == 0) for (int i = lo; i <= hi; i++) seq.push_back(i);
    else if (m == 1) for (int i = hi; i >= lo; i--) seq.push_back(i);
    else if (m == 2) begin
      for (int i = lo; i <= hi; i++) seq.push_back(i);
      for (int i = hi - 1; i >= lo; i--) seq.push_back(i);
    end else if (lo == hi) seq.push_back(lo);
    else begin
      int v, d;
      v = lo;
      d = 1;
      for (int i = 0; i < 64; i++) begin
        seq.push_back(v);
        if (v == hi) d = -1;
        else if (v == lo) d = 1;
        v += d;
      end
    end
    finite = !(m == 3 && lo != hi);
    @(negedge clk);
    mode = 2'(m); lo_sel = 3'(lo); hi_sel = 3'(hi); dwell = 16'(dw); start = 1;
    k = cyc + 1;
    if (lo > hi) begin
      sbq.push_back(ev_t'{3, cur_exp, k});
      @(negedge clk);
      start = 0;
      repeat (3) @(negedge clk);
      chk("sb_drained", sbq.size(), 0);
      return;
    end
    per = (dw == 0 ? 1 : dw) + XTRA;
    n = seq.size();
    s = stop_rel > 0 ? k + stop_rel : 1 << 30;
    dc = finite ? k + 1 + n * per : 1 << 30;
    endc = dc < s ? dc : s;
    sbq.push_back(ev_t'{0, seq[0], k});
    for (int i = 1; i < n; i++) begin
      c = k + 1 + i * per;
      if (c < endc) sbq.push_back(ev_t'{1, seq[i], c});
    end
    if (dc < s) sbq.push_back(ev_t'{2, seq[n-1], dc});
    busy_lo = k;
    busy_hi = endc - 1;
    @(negedge clk);
    start = 0;
    mode = 2'($urandom); lo_sel = 3'($urandom); hi_sel = 3'($urandom); dwell = 16'($urandom_range(0, 9));
    if (poke) begin
      @(negedge clk);
      start = 1;
      lo_sel = 3'($urandom);
      @(negedge clk);
      start = 0;
    end
    if (stop_rel > 0) begin
      while (cyc < s - 1) @(negedge clk);
      stop = 1;
      @(negedge clk);
      stop = 0;
    end
    while (cyc < endc + 2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
  endtask
  task automatic check_reset_outputs();
    chk("rst_freq", int'(freq_select), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gen_reset", int'(gen_reset), 0);
    chk("rst_step", int'(step_pulse), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int k, m, lo, hi, sr;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 0;
    sweep(0, 2, 4, 3, 0, 1);
    sweep(2, 1, 3, 1, 0, 0);
    sweep(3, 0, 1, 2, 9, 0);
    sweep(0, 5, 2, 3, 0, 0);
    sweep(0, 3, 5, 0, 0, 0);
    sweep(3, 6, 6, 2, 0, 0);
    sweep(1, 0, 7, 1, 0, 1);
    @(negedge clk);
    mode = 0; lo_sel = 1; hi_sel = 4; dwell = 2; start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    repeat (3) @(negedge clk);
    // reset in the middle of a sweep
    @(negedge clk);
    mode = 0; lo_sel = 0; hi_sel = 7; dwell = 2; start = 1;
    k = cyc + 1;
    sbq.push_back(ev_t'{0, 0, k});
    sbq.push_back(ev_t'{1, 1, k + 3});
    busy_lo = k;
    busy_hi = k + 3;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_reset_outputs();
    cur_exp = 0;
    reset = 0;
    chk("sb_drained", sbq.size(), 0);
    for (int t = 0; t < 40; t++) begin
      m = $urandom_range(0, 3);
      lo = $urandom_range(0, 7);
      hi = $urandom_range(0, 7);
      sr = ((m == 3 && lo != hi) || $urandom_range(0, 3) == 0) ? $urandom_range(4, 40) : 0;
      sweep(m, lo, hi, $urandom_range(0, 4), sr, 1'($urandom_range(0, 1)));
    end
`ifdef SWEEP_SYNC_ZERO_EN
    @(negedge clk);
    wave_in = 8'd7;
    mode = 0; lo_sel = 0; hi_sel = 1; dwell = 2; start = 1;
    k = cyc + 1;
    sbq.push_back(ev_t'{0, 0, k});
    sbq.push_back(ev_t'{1, 1, k + 7});
    sbq.push_back(ev_t'{2, 1, k + 10});
    busy_lo = k;
    busy_hi = k + 9;
    @(negedge clk);
    start = 0;
    while (cyc < k + 6) @(negedge clk);
    wave_in = 8'd0;
    while (cyc < k + 12) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
